// File: rtl/interpolating_lut_loader.sv
// Programming-side loader for the interpolating LUT: software fills a staging RAM,
// then a start pulse streams every entry in address order over a valid/ready source.
module interpolating_lut_loader #(
    parameter int G_ADDR_WIDTH   = 10,
    parameter int G_DWIDTH       = 24,
    parameter int G_DONE_TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [G_ADDR_WIDTH-1:0] cfg_wr_addr,
    input  logic [G_DWIDTH-1:0]     cfg_wr_data,
    input  logic                    cfg_wr_en,
    input  logic                    start,
    output logic                    busy,
    output logic                    load_done,
    output logic                    load_err,
    output logic                    wr_while_busy,
    output logic [G_DWIDTH-1:0]     lut_prog_dout,
    output logic                    lut_prog_dout_valid,
    input  logic                    lut_prog_dout_ready,
    input  logic                    lut_prog_done,
    output logic [2:0]              dbg_state
);

    localparam int DEPTH = 2 ** G_ADDR_WIDTH;
    localparam int TMO_W = $clog2(G_DONE_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_SEND      = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_DONE      = 3'd4,
        S_ERROR     = 3'd5
    } state_t;

    state_t                  state_q;
    logic [G_ADDR_WIDTH-1:0] cnt_q;
    logic [TMO_W-1:0]        tmo_q;
    logic                    busy_q;
    logic                    load_done_q;
    logic                    load_err_q;
    logic                    wr_while_busy_q;
    logic [G_DWIDTH-1:0]     dout_q;
    logic                    valid_q;

    logic [G_DWIDTH-1:0]     ram_q [DEPTH];

    logic cfg_open;
    logic last_entry;
    logic [G_ADDR_WIDTH-1:0] cnt_d;

    // Staging RAM accepts writes only while no load is in flight.
    assign cfg_open   = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR);
    assign last_entry = (cnt_q == {G_ADDR_WIDTH{1'b1}});
    assign cnt_d      = cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (cfg_wr_en && cfg_open) begin
            ram_q[cfg_wr_addr] <= cfg_wr_data;
        end
    end

    // Valid/ready source: a beat transfers on a rising edge where valid and ready are
    // both high; once valid rises, valid and data hold until that edge, then valid drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            tmo_q           <= '0;
            busy_q          <= 1'b0;
            load_done_q     <= 1'b0;
            load_err_q      <= 1'b0;
            wr_while_busy_q <= 1'b0;
            dout_q          <= '0;
            valid_q         <= 1'b0;
        end else begin
            if (cfg_wr_en && !cfg_open) begin
                wr_while_busy_q <= 1'b1;
            end
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        load_done_q     <= 1'b0;
                        load_err_q      <= 1'b0;
                        wr_while_busy_q <= 1'b0;
                        cnt_q           <= '0;
                        busy_q          <= 1'b1;
                        state_q         <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    dout_q  <= ram_q[cnt_q];
                    valid_q <= 1'b1;
                    state_q <= S_SEND;
                end
                S_SEND: begin
                    if (lut_prog_dout_ready) begin
                        valid_q <= 1'b0;
                        if (last_entry) begin
                            tmo_q   <= TMO_W'(G_DONE_TIMEOUT);
                            state_q <= S_WAIT_DONE;
                        end else begin
                            cnt_q   <= cnt_d;
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_WAIT_DONE: begin
                    // Error lands exactly G_DONE_TIMEOUT cycles after the last handshake.
                    if (lut_prog_done) begin
                        busy_q      <= 1'b0;
                        load_done_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else if (tmo_q <= TMO_W'(1)) begin
                        tmo_q      <= '0;
                        busy_q     <= 1'b0;
                        load_err_q <= 1'b1;
                        state_q    <= S_ERROR;
                    end else begin
                        tmo_q <= tmo_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy                = busy_q;
    assign load_done           = load_done_q;
    assign load_err            = load_err_q;
    assign wr_while_busy       = wr_while_busy_q;
    assign lut_prog_dout       = dout_q;
    assign lut_prog_dout_valid = valid_q;
    assign dbg_state           = state_q;

endmodule

// File: tb/tb_interpolating_lut_loader.sv
// Directed bench for interpolating_lut_loader (16-entry staging RAM, 24-bit entries).
module tb_interpolating_lut_loader;

    localparam int AW  = 4;
    localparam int DW  = 24;
    localparam int TO  = 16;
    localparam int NUM = 2 ** AW;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] cfg_wr_addr;
    logic [DW-1:0] cfg_wr_data;
    logic          cfg_wr_en;
    logic          start;
    logic          busy;
    logic          load_done;
    logic          load_err;
    logic          wr_while_busy;
    logic [DW-1:0] lut_prog_dout;
    logic          lut_prog_dout_valid;
    logic          lut_prog_dout_ready = 1'b0;
    logic          lut_prog_done = 1'b0;
    logic [2:0]    dbg_state;

    interpolating_lut_loader #(
        .G_ADDR_WIDTH  (AW),
        .G_DWIDTH      (DW),
        .G_DONE_TIMEOUT(TO)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .cfg_wr_addr        (cfg_wr_addr),
        .cfg_wr_data        (cfg_wr_data),
        .cfg_wr_en          (cfg_wr_en),
        .start              (start),
        .busy               (busy),
        .load_done          (load_done),
        .load_err           (load_err),
        .wr_while_busy      (wr_while_busy),
        .lut_prog_dout      (lut_prog_dout),
        .lut_prog_dout_valid(lut_prog_dout_valid),
        .lut_prog_dout_ready(lut_prog_dout_ready),
        .lut_prog_done      (lut_prog_done),
        .dbg_state          (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_mem [NUM];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] got_q [$];
    int base     = 0;
    int rdy_mode = 1;
    bit done_en  = 1'b1;
    int cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- consumer model ----------------
    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic [DW-1:0] prev_dout  = '0;

    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                check("hold_valid", 32'(lut_prog_dout_valid), 32'd1);
                check("hold_dout", 32'(lut_prog_dout), 32'(prev_dout));
            end
            if (lut_prog_dout_valid && lut_prog_dout_ready) got_q.push_back(lut_prog_dout);
            prev_valid = lut_prog_dout_valid;
            prev_ready = lut_prog_dout_ready;
            prev_dout  = lut_prog_dout;
        end
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       lut_prog_dout_ready = 1'b0;
            1:       lut_prog_dout_ready = 1'b1;
            default: lut_prog_dout_ready = ($urandom_range(0, 9) < 6);
        endcase
        lut_prog_done = done_en && ((got_q.size() - base) >= NUM);
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cfg_wr_addr = a;
        cfg_wr_data = d;
        cfg_wr_en   = 1'b1;
        tick(1);
        cfg_wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        base  = got_q.size();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget, output int n);
        n = 0;
        while (busy && n < budget) begin
            tick(1);
            n++;
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_beats(input string tag, input int beats);
        int n = 0;
        while ((got_q.size() - base) < beats && n < 200) begin
            tick(1);
            n++;
        end
        check({tag, "_beats_seen"}, 32'((got_q.size() - base) >= beats), 32'd1);
    endtask

    task automatic check_load(input string tag);
        for (int i = 0; i < NUM; i++) exp_q.push_back(exp_mem[i]);
        check({tag, "_beat_count"}, 32'(got_q.size() - base), 32'(NUM));
        for (int i = 0; i < NUM; i++) begin
            if (base + i < got_q.size())
                check($sformatf("%s_beat%0d", tag, i), 32'(got_q[base + i]), 32'(exp_q[0]));
            void'(exp_q.pop_front());
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1; cfg_wr_addr = '0; cfg_wr_data = '0; cfg_wr_en = 1'b0; start = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_err", 32'(load_err), 32'd0);
        check("rst_wwb", 32'(wr_while_busy), 32'd0);
        check("rst_valid", 32'(lut_prog_dout_valid), 32'd0);
        check("rst_dout", 32'(lut_prog_dout), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);

        // 1: ready tied high, 2 cycles per beat plus one cycle of done latency
        for (int i = 0; i < NUM; i++) begin
            exp_mem[i] = 24'h100000 + DW'(i);
            cfg_write(AW'(i), exp_mem[i]);
        end
        pulse_start();
        check("t1_busy", 32'(busy), 32'd1);
        wait_idle("t1", 200, cyc);
        check("t1_cycles", 32'(cyc), 32'(2 * NUM + 1));
        check_load("t1");
        check("t1_done", 32'(load_done), 32'd1);
        check("t1_err", 32'(load_err), 32'd0);

        // 2: random backpressure
        rdy_mode = 2;
        pulse_start();
        wait_idle("t2", 400, cyc);
        check_load("t2");
        check("t2_done", 32'(load_done), 32'd1);
        rdy_mode = 1;

        // 3: done never arrives
        done_en = 1'b0;
        pulse_start();
        wait_beats("t3", NUM);
        check("t3_err_early", 32'(load_err), 32'd0);
        cyc = 0;
        while (!load_err && cyc < 100) begin
            tick(1);
            cyc++;
        end
        check("t3_err_latency", 32'(cyc), 32'(TO));
        check("t3_err", 32'(load_err), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_done", 32'(load_done), 32'd0);
        done_en = 1'b1;

        // 4: write while busy is dropped
        pulse_start();
        check("t4_err_clr", 32'(load_err), 32'd0);
        check("t4_busy", 32'(busy), 32'd1);
        wait_beats("t4", 4);
        cfg_write(4'd3, 24'hFFFFFF);
        check("t4_wwb_set", 32'(wr_while_busy), 32'd1);
        wait_idle("t4", 200, cyc);
        check_load("t4");
        pulse_start();
        check("t4_wwb_clr", 32'(wr_while_busy), 32'd0);
        wait_idle("t4r", 200, cyc);
        check_load("t4r");
        cfg_write(4'd3, 24'hABCDEF);
        exp_mem[3] = 24'hABCDEF;
        check("t4_wwb_idle_wr", 32'(wr_while_busy), 32'd0);

        // 5: reset mid-load
        pulse_start();
        wait_beats("t5", 7);
        tick(1);
        check("t5_valid_pre", 32'(lut_prog_dout_valid), 32'd1);
        reset = 1'b1;
        tick(1);
        check("t5_valid", 32'(lut_prog_dout_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_state", 32'(dbg_state), 32'd0);
        reset = 1'b0;
        tick(1);
        pulse_start();
        wait_idle("t5", 200, cyc);
        check_load("t5");
        check("t5_done", 32'(load_done), 32'd1);

        // 6: start while busy ignored; start in DONE reloads
        pulse_start();
        wait_beats("t6", 3);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_idle("t6", 200, cyc);
        tick(4);
        check_load("t6");
        pulse_start();
        check("t6_done_clr", 32'(load_done), 32'd0);
        check("t6_busy", 32'(busy), 32'd1);
        wait_idle("t6r", 200, cyc);
        check_load("t6r");
        check("t6_done", 32'(load_done), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
